// File: rtl/mac_csr_pkg.sv
// Shared constants and types for the mac core CSR controller.
package mac_csr_pkg;

  localparam int F_W   = 12;
  localparam int A_W   = 24;
  localparam int R_W   = 25;
  localparam int CNT_W = 4;

  localparam int unsigned OFF_F1     = 'h00;
  localparam int unsigned OFF_F2     = 'h08;
  localparam int unsigned OFF_A1     = 'h10;
  localparam int unsigned OFF_CTRL   = 'h18;
  localparam int unsigned OFF_STATUS = 'h20;
  localparam int unsigned OFF_RESULT = 'h28;
  localparam int unsigned OFF_COUNT  = 'h30;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ACC    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_OVERRUN = 3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} seq_state_e;

endpackage

// File: rtl/mac_csr_seq.sv
// Operation sequencer: waits out the core pipeline latency after a start,
// then issues a one-cycle capture pulse.
module mac_csr_seq
  import mac_csr_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic arst,
  input  logic i_start,
  output logic o_busy,
  output logic o_capture_pulse
);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_cap;

  // r_cap mirrors the CAPTURE state so the top latches result on its exit edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_cap <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_WAIT;
          r_cnt   <= CNT_W'(LATENCY - 1);
          r_busy  <= 1'b1;
        end
        S_WAIT: if (r_cnt == '0) begin
          r_state <= S_CAPTURE;
          r_cap   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy          = r_busy;
  assign o_capture_pulse = r_cap;

endmodule

// File: rtl/mac_csr_ctrl.sv
// CSR block for the mac core: operand registers, start/capture sequencing,
// status/count tracking and a level interrupt.
module mac_csr_ctrl
  import mac_csr_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ren,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              waddr_error,
  output logic              raddr_error,
  output logic [F_W-1:0]    f1_rsc_dat,
  output logic [F_W-1:0]    f2_rsc_dat,
  output logic [A_W-1:0]    a1_rsc_dat,
  input  logic [R_W-1:0]    result_rsc_dat,
  output logic              irq
);

  logic [F_W-1:0]    r_f1, r_f2;
  logic [A_W-1:0]    r_a1;
  logic              r_acc, r_irq_en;
  logic              r_done, r_ovf, r_overrun;
  logic [R_W-1:0]    r_result;
  logic [31:0]       r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              r_raddr_err, r_waddr_err, r_irq;

  logic w_busy, w_cap;
  logic w_sel_f1, w_sel_f2, w_sel_a1, w_sel_ctrl, w_sel_status, w_sel_result, w_sel_count;
  logic w_wr_ok, w_wr_op, w_wr_ctrl, w_wr_status, w_start_req, w_start;
  logic w_overrun_set, w_ovf_set;
  logic w_rd_ok;
  logic [DATA_W-1:0] w_rd_val;
  logic w_unused;

  assign w_sel_f1     = (addr == ADDR_W'(OFF_F1));
  assign w_sel_f2     = (addr == ADDR_W'(OFF_F2));
  assign w_sel_a1     = (addr == ADDR_W'(OFF_A1));
  assign w_sel_ctrl   = (addr == ADDR_W'(OFF_CTRL));
  assign w_sel_status = (addr == ADDR_W'(OFF_STATUS));
  assign w_sel_result = (addr == ADDR_W'(OFF_RESULT));
  assign w_sel_count  = (addr == ADDR_W'(OFF_COUNT));

  assign w_wr_ok     = w_sel_f1 | w_sel_f2 | w_sel_a1 | w_sel_ctrl | w_sel_status;
  assign w_wr_op     = wen & (w_sel_f1 | w_sel_f2 | w_sel_a1);
  assign w_wr_ctrl   = wen & w_sel_ctrl;
  assign w_wr_status = wen & w_sel_status;
  assign w_start_req = w_wr_ctrl & wdata[CTRL_START];
  assign w_start     = w_start_req & ~w_busy;
  // Operands must stay frozen while the core computes; any attempt is flagged.
  assign w_overrun_set = w_busy & (w_wr_op | w_start_req);
  assign w_ovf_set     = w_cap & r_acc & (result_rsc_dat[R_W-1] ^ result_rsc_dat[R_W-2]);
  assign w_unused      = ^wdata[DATA_W-1:A_W];

  mac_csr_seq #(.LATENCY(LATENCY)) u_seq (
    .clk             (clk),
    .arst            (arst),
    .i_start         (w_start),
    .o_busy          (w_busy),
    .o_capture_pulse (w_cap)
  );

  always_comb begin
    w_rd_val = '0;
    w_rd_ok  = 1'b1;
    if (w_sel_f1)          w_rd_val = DATA_W'(r_f1);
    else if (w_sel_f2)     w_rd_val = DATA_W'(r_f2);
    else if (w_sel_a1)     w_rd_val = DATA_W'(r_a1);
    else if (w_sel_ctrl) begin
      w_rd_val[CTRL_ACC]    = r_acc;
      w_rd_val[CTRL_IRQ_EN] = r_irq_en;
    end else if (w_sel_status) begin
      w_rd_val[ST_BUSY]    = w_busy;
      w_rd_val[ST_DONE]    = r_done;
      w_rd_val[ST_OVF]     = r_ovf;
      w_rd_val[ST_OVERRUN] = r_overrun;
    end
    else if (w_sel_result) w_rd_val = {{(DATA_W-R_W){r_result[R_W-1]}}, r_result};
    else if (w_sel_count)  w_rd_val = DATA_W'(r_count);
    else                   w_rd_ok  = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_f1        <= '0;
      r_f2        <= '0;
      r_a1        <= '0;
      r_acc       <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_overrun   <= 1'b0;
      r_result    <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_raddr_err <= 1'b0;
      r_waddr_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (wen && w_sel_f1 && !w_busy) r_f1 <= wdata[F_W-1:0];
      if (wen && w_sel_f2 && !w_busy) r_f2 <= wdata[F_W-1:0];
      if (w_cap && r_acc)                    r_a1 <= result_rsc_dat[A_W-1:0];
      else if (wen && w_sel_a1 && !w_busy)   r_a1 <= wdata[A_W-1:0];
      if (w_wr_ctrl) begin
        r_acc    <= wdata[CTRL_ACC];
        r_irq_en <= wdata[CTRL_IRQ_EN];
      end
      if (w_cap) begin
        r_result <= result_rsc_dat;
        r_count  <= r_count + 32'd1;
      end
      // Set beats W1C when both land on the same edge.
      r_done    <= w_cap         | (r_done    & ~(w_wr_status & wdata[ST_DONE]));
      r_ovf     <= w_ovf_set     | (r_ovf     & ~(w_wr_status & wdata[ST_OVF]));
      r_overrun <= w_overrun_set | (r_overrun & ~(w_wr_status & wdata[ST_OVERRUN]));
      r_irq       <= r_done & r_irq_en;
      r_waddr_err <= wen & ~w_wr_ok;
      r_raddr_err <= ren & ~w_rd_ok;
      if (ren) r_rdata <= w_rd_ok ? w_rd_val : '0;
    end
  end

  assign rdata       = r_rdata;
  assign raddr_error = r_raddr_err;
  assign waddr_error = r_waddr_err;
  assign f1_rsc_dat  = r_f1;
  assign f2_rsc_dat  = r_f2;
  assign a1_rsc_dat  = r_a1;
  assign irq         = r_irq;

endmodule
